// File: rtl/sound_pkg.sv
// Shared types, FSM encoding and melody ROM for the sound sequencer.
package sound_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_START = 2'd1,
    EVT_FOOD  = 2'd2,
    EVT_GO    = 2'd3
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  typedef struct packed {
    logic [16:0] hp;
    logic [9:0]  dur;
    logic        last;
  } note_t;

  localparam int ROM_DEPTH = 9;

  localparam logic [3:0] BASE_START = 4'd0;
  localparam logic [3:0] BASE_FOOD  = 4'd3;
  localparam logic [3:0] BASE_GO    = 4'd5;

  // hp = 0 encodes a rest; last marks the final note of each melody.
  localparam note_t MELODY_ROM [ROM_DEPTH] = '{
    {17'd47801, 10'd100, 1'b0},
    {17'd37936, 10'd100, 1'b0},
    {17'd31888, 10'd150, 1'b1},
    {17'd28409, 10'd60,  1'b0},
    {17'd18954, 10'd80,  1'b1},
    {17'd63776, 10'd200, 1'b0},
    {17'd0,     10'd50,  1'b0},
    {17'd75758, 10'd200, 1'b0},
    {17'd95420, 10'd400, 1'b1}
  };

  function automatic note_t rom_read(input logic [3:0] idx);
    note_t n;
    n = '0;
    if (idx < 4'(ROM_DEPTH)) begin
      n = MELODY_ROM[idx];
    end else begin
      n = '0;
    end
    return n;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Duration prescaler: one-cycle tick every DIV clocks, synchronously restartable.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(DIV - 1));

  // Next count: wrap on tick, clear on restart.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Event-driven melody scheduler: arbitrates game events and walks note lists
// from the ROM, driving registered half-period/enable to the tone generator.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int HP_W     = 17
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            evt_start,
  input  logic            evt_food,
  input  logic            evt_gameover,
  output logic [HP_W-1:0] tone_half_period,
  output logic            tone_en,
  output logic            busy,
  output logic [1:0]      cur_evt
);

  state_t          state_q, state_d;
  evt_t            evt_q, evt_d;
  logic [3:0]      idx_q, idx_d;
  logic            first_q, first_d;
  note_t           note_q, note_d;
  logic [9:0]      dur_cnt_q, dur_cnt_d;
  logic            pend_start_q, pend_start_d;
  logic            pend_food_q, pend_food_d;
  logic            pend_go_q, pend_go_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic [1:0]      cur_q, cur_d;

  note_t rom_s;
  logic  tick_s;
  logic  restart_s;
  logic  note_done_s;
  logic  clr_s;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart_i (restart_s),
    .tick_o    (tick_s)
  );

  assign rom_s       = rom_read(idx_q);
  assign restart_s   = (state_q != ST_PLAY);
  assign note_done_s = tick_s && (dur_cnt_q == (note_q.dur - 10'd1));
  // Flags drop on the first LOAD of a melody; a same-edge pulse still wins.
  assign clr_s       = (state_q == ST_LOAD) && first_q;

  // Pending flags: set by pulse, cleared on melody load; gameover also flushes the others.
  always_comb begin
    pend_go_d    = (pend_go_q && !(clr_s && (evt_q == EVT_GO))) || evt_gameover;
    pend_food_d  = (pend_food_q && !(clr_s && ((evt_q == EVT_FOOD) || (evt_q == EVT_GO))))
                   || evt_food;
    pend_start_d = (pend_start_q && !(clr_s && ((evt_q == EVT_START) || (evt_q == EVT_GO))))
                   || evt_start;
  end

  // Next-state logic and registered-output precompute.
  always_comb begin
    state_d   = state_q;
    evt_d     = evt_q;
    idx_d     = idx_q;
    first_d   = first_q;
    note_d    = note_q;
    dur_cnt_d = dur_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_go_q) begin
          evt_d = EVT_GO;   idx_d = BASE_GO;    first_d = 1'b1; state_d = ST_LOAD;
        end else if (pend_food_q) begin
          evt_d = EVT_FOOD; idx_d = BASE_FOOD;  first_d = 1'b1; state_d = ST_LOAD;
        end else if (pend_start_q) begin
          evt_d = EVT_START; idx_d = BASE_START; first_d = 1'b1; state_d = ST_LOAD;
        end else begin
          evt_d = EVT_NONE;
        end
      end
      ST_LOAD: begin
        note_d    = rom_s;
        dur_cnt_d = 10'd0;
        first_d   = 1'b0;
        state_d   = ST_PLAY;
      end
      ST_PLAY: begin
        if (pend_go_q && (evt_q != EVT_GO)) begin
          evt_d = EVT_GO; idx_d = BASE_GO; first_d = 1'b1; state_d = ST_LOAD;
        end else if (note_done_s) begin
          if (note_q.last) begin
            evt_d   = EVT_NONE;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_LOAD;
          end
        end else if (tick_s) begin
          dur_cnt_d = dur_cnt_q + 10'd1;
        end else begin
          dur_cnt_d = dur_cnt_q;
        end
      end
      default: begin
        evt_d   = EVT_NONE;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    cur_d  = busy_d ? evt_d : EVT_NONE;
    hp_d   = (state_d == ST_PLAY) ? HP_W'(note_d.hp) : '0;
    en_d   = (state_d == ST_PLAY) && (note_d.hp != 17'd0);
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      evt_q        <= EVT_NONE;
      idx_q        <= 4'd0;
      first_q      <= 1'b0;
      note_q       <= '0;
      dur_cnt_q    <= 10'd0;
      pend_start_q <= 1'b0;
      pend_food_q  <= 1'b0;
      pend_go_q    <= 1'b0;
      hp_q         <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      cur_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      evt_q        <= evt_d;
      idx_q        <= idx_d;
      first_q      <= first_d;
      note_q       <= note_d;
      dur_cnt_q    <= dur_cnt_d;
      pend_start_q <= pend_start_d;
      pend_food_q  <= pend_food_d;
      pend_go_q    <= pend_go_d;
      hp_q         <= hp_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      cur_q        <= cur_d;
    end
  end

  assign tone_half_period = hp_q;
  assign tone_en          = en_q;
  assign busy             = busy_q;
  assign cur_evt          = cur_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with a short duration tick.
module tb_sound_sequencer;

  localparam int TD = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        evt_start = 1'b0;
  logic        evt_food = 1'b0;
  logic        evt_gameover = 1'b0;
  logic [16:0] tone_half_period;
  logic        tone_en;
  logic        busy;
  logic [1:0]  cur_evt;

  int n_tests = 0;
  int n_fail  = 0;

  sound_sequencer #(.TICK_DIV(TD), .HP_W(17)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .evt_start        (evt_start),
    .evt_food         (evt_food),
    .evt_gameover     (evt_gameover),
    .tone_half_period (tone_half_period),
    .tone_en          (tone_en),
    .busy             (busy),
    .cur_evt          (cur_evt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic f, input logic g);
    evt_start = s; evt_food = f; evt_gameover = g;
    step(1);
    evt_start = 1'b0; evt_food = 1'b0; evt_gameover = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int cycles, output bit timed_out);
    cycles = 0;
    timed_out = 1'b1;
    for (int i = 0; i < max; i++) begin
      step(1);
      cycles++;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_quiet(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      step(1);
      if (busy || tone_en) act++;
    end
    check_eq(tag, 32'(act), 32'd0);
  endtask

  // Follows a full gameover melody from the pulse edge until idle.
  task automatic go_run(input string tag);
    int busy_cyc;
    int silent_cyc;
    bit done;
    busy_cyc = 0; silent_cyc = 0; done = 1'b0;
    for (int i = 1; i <= 20000 && !done; i++) begin
      step(1);
      if (i == 2) begin
        check_eq({tag, "_n0_hp"}, 32'(tone_half_period), 32'd63776);
        check_eq({tag, "_cur"}, 32'(cur_evt), 32'd3);
      end
      if (i == 200*TD + 3) begin
        check_eq({tag, "_rest_en"}, 32'(tone_en), 32'd0);
        check_eq({tag, "_rest_busy"}, 32'(busy), 32'd1);
      end
      if (i == 250*TD + 4) check_eq({tag, "_n2_hp"}, 32'(tone_half_period), 32'd75758);
      if (i == 450*TD + 5) check_eq({tag, "_n3_hp"}, 32'(tone_half_period), 32'd95420);
      if (busy) begin
        busy_cyc++;
        if (!tone_en) silent_cyc++;
      end else begin
        done = 1'b1;
      end
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_cyc"}, 32'(busy_cyc), 32'(850*TD + 4));
    check_eq({tag, "_silent_cyc"}, 32'(silent_cyc), 32'(50*TD + 4));
  endtask

  initial begin
    int  cyc;
    bit  to;

    reset_n = 1'b0;
    step(3);
    check_eq("rst_hp", 32'(tone_half_period), 32'd0);
    check_eq("rst_en", 32'(tone_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cur", 32'(cur_evt), 32'd0);
    reset_n = 1'b1;
    step(2);
    check_eq("post_rst_busy", 32'(busy), 32'd0);

    // Single food melody.
    pulse(1'b0, 1'b1, 1'b0);
    step(2);
    check_eq("food_n0_hp", 32'(tone_half_period), 32'd28409);
    check_eq("food_n0_en", 32'(tone_en), 32'd1);
    check_eq("food_cur", 32'(cur_evt), 32'd2);
    step(60*TD - 1);
    check_eq("food_n0_end_en", 32'(tone_en), 32'd1);
    step(1);
    check_eq("food_load_en", 32'(tone_en), 32'd0);
    check_eq("food_load_busy", 32'(busy), 32'd1);
    step(1);
    check_eq("food_n1_hp", 32'(tone_half_period), 32'd18954);
    check_eq("food_n1_en", 32'(tone_en), 32'd1);
    step(80*TD - 1);
    check_eq("food_n1_end_en", 32'(tone_en), 32'd1);
    step(1);
    check_eq("food_done_busy", 32'(busy), 32'd0);
    check_eq("food_done_cur", 32'(cur_evt), 32'd0);
    check_eq("food_done_en", 32'(tone_en), 32'd0);

    // Full gameover melody.
    step(5);
    pulse(1'b0, 1'b0, 1'b1);
    go_run("go");
    check_quiet("go_after", 20);

    // Gameover preempts start; start is not replayed.
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    check_eq("abort_start_hp", 32'(tone_half_period), 32'd47801);
    check_eq("abort_start_cur", 32'(cur_evt), 32'd1);
    step(50*TD);
    pulse(1'b0, 1'b0, 1'b1);
    step(1);
    check_eq("abort_load_en", 32'(tone_en), 32'd0);
    check_eq("abort_load_cur", 32'(cur_evt), 32'd3);
    step(1);
    check_eq("abort_go_hp", 32'(tone_half_period), 32'd63776);
    check_eq("abort_go_en", 32'(tone_en), 32'd1);
    wait_idle(20000, cyc, to);
    check_eq("abort_timeout", 32'(to), 32'd0);
    check_eq("abort_go_len", 32'(cyc), 32'(850*TD + 3));
    check_quiet("abort_no_replay", 50);

    // Food queued behind start.
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    check_eq("queue_s0_hp", 32'(tone_half_period), 32'd47801);
    step(30*TD);
    pulse(1'b0, 1'b1, 1'b0);
    step(70*TD);
    check_eq("queue_s1_hp", 32'(tone_half_period), 32'd37936);
    check_eq("queue_s1_cur", 32'(cur_evt), 32'd1);
    step(100*TD + 1);
    check_eq("queue_s2_hp", 32'(tone_half_period), 32'd31888);
    wait_idle(20000, cyc, to);
    check_eq("queue_start_timeout", 32'(to), 32'd0);
    check_eq("queue_s2_len", 32'(cyc), 32'(150*TD));
    check_eq("queue_idle_cur", 32'(cur_evt), 32'd0);
    step(1);
    check_eq("queue_load_busy", 32'(busy), 32'd1);
    check_eq("queue_load_cur", 32'(cur_evt), 32'd2);
    check_eq("queue_load_en", 32'(tone_en), 32'd0);
    step(1);
    check_eq("queue_food_hp", 32'(tone_half_period), 32'd28409);
    wait_idle(20000, cyc, to);
    check_eq("queue_food_timeout", 32'(to), 32'd0);
    check_eq("queue_food_len", 32'(cyc), 32'(140*TD + 1));

    // All three at once: only gameover plays.
    step(3);
    pulse(1'b1, 1'b1, 1'b1);
    go_run("all3");
    check_quiet("all3_after", 30);

    // Asynchronous reset mid-note drops outputs and pending events.
    pulse(1'b0, 1'b1, 1'b0);
    step(20);
    pulse(1'b1, 1'b0, 1'b0);
    step(10);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_hp", 32'(tone_half_period), 32'd0);
    check_eq("arst_en", 32'(tone_en), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_cur", 32'(cur_evt), 32'd0);
    step(2);
    #2 reset_n = 1'b1;
    check_quiet("arst_quiet", 100);
    pulse(1'b0, 1'b1, 1'b0);
    step(2);
    check_eq("arst_restart_hp", 32'(tone_half_period), 32'd28409);
    wait_idle(20000, cyc, to);
    check_eq("arst_restart_timeout", 32'(to), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Event-driven melody scheduler that sits between the game logic and the square-wave tone generator (`soundgen` datapath). It accepts single-cycle game event pulses, arbitrates them by priority, and steps through per-event note lists held in a ROM. For each note it drives a half-period count and tone enable to the tone generator for an exact duration.

## Interface
Parameters:
- `TICK_DIV`, 50_000: clock cycles per duration tick (1 ms at 50 MHz). Benches override this to a small value.
- `HP_W`, 17: width of the half-period count.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `evt_start`  in  1  one-cycle pulse: game start.
- `evt_food`  in  1  one-cycle pulse: food eaten.
- `evt_gameover`  in  1  one-cycle pulse: game over.
- `tone_half_period`  out  HP_W  half-period in clocks, for the tone generator.
- `tone_en`  out  1  tone generator enable. Low means silent or rest.
- `busy`  out  1  a melody is in progress.
- `cur_evt`  out  2  melody playing: 0 none, 1 start, 2 food, 3 gameover.

## Operation
- Pending flags `pend_start`, `pend_food`, `pend_go`:
  - Each is set by its pulse.
  - It is cleared when its melody is loaded.
  - A repeat pulse while the flag is already set is absorbed.
- Priority: gameover > food > start.
- FSM states: IDLE, LOAD, PLAY.
  - IDLE: if any flag is pending, latch the highest-priority event, set the note index to its base, and go to LOAD.
  - LOAD: register the ROM entry (half_period, dur, last). Restart the tick prescaler and duration counter. Go to PLAY.
  - PLAY: count ticks. When the count equals dur:
    - if `last` is set, go to IDLE;
    - otherwise increment the index and go to LOAD.
- Preemption:
  - In PLAY, a pending gameover while `cur_evt` is not 3 aborts the current melody and goes to LOAD of gameover note 0.
  - Food and start never preempt. They wait in their pending flags.
- Starting the gameover melody clears `pend_food` and `pend_start`.
- Note with half_period = 0 is a rest: `tone_en` = 0 for its duration.
- Melodies (half_period, dur in ms):
  - start: (47801, 100), (37936, 100), (31888, 150).
  - food: (28409, 60), (18954, 80).
  - gameover: (63776, 200), (0, 50), (75758, 200), (95420, 400).
- `busy` = 1 in LOAD and PLAY.
- `cur_evt` holds the latched event while busy and is 0 in IDLE.

## Timing
- Reset values:
  - FSM in IDLE.
  - All pending flags 0.
  - `tone_half_period` = 0, `tone_en` = 0, `busy` = 0, `cur_evt` = 0.
  - Prescaler and counters 0.
- Reset mid-melody silences the output immediately (asynchronous). No pending event survives reset.
- Latency from idle: a pulse sampled at edge k sets the flag at k. IDLE→LOAD at k+1, LOAD→PLAY at k+2. `tone_*` and `busy` are valid from edge k+2.
- All outputs are registered.
- Note length is exactly dur × TICK_DIV clocks in PLAY, plus 1 LOAD cycle between notes. `tone_en` drops to 0 during LOAD.
- After the last note, there is 1 IDLE cycle before the next pending melody enters LOAD.
- Simultaneous pulses in one cycle: all flags are set, and arbitration takes gameover first.
- A pulse arriving on the same edge that its flag is cleared (in LOAD) is kept pending.

## Structure
- Package `sound_pkg`:
  - `evt_t` enum (EVT_NONE, EVT_START, EVT_FOOD, EVT_GO);
  - `note_t` struct {hp[16:0], dur[9:0], last};
  - the melody ROM constant array;
  - per-event base index constants.
- Sub-module `tick_gen`: prescaler with synchronous restart input and a one-cycle `tick` output every TICK_DIV clocks.
- The ROM is combinational from the package constant. The registered note lives in the top module.

## Test plan
All scenarios use TICK_DIV = 50.
- Reset, then a single `evt_food` pulse:
  - `tone_en` = 1 and hp = 28409 two cycles later, for 3000 clocks;
  - 1 cycle with `tone_en` = 0;
  - hp = 18954 for 4000 clocks;
  - then `busy` = 0 and `cur_evt` = 0.
- `evt_gameover`: the notes play in order. The rest shows `tone_en` = 0 for 2500 clocks. Total busy time = 42500 + 4 clocks.
- `evt_start`, then `evt_gameover` 1000 clocks later:
  - start is aborted;
  - gameover hp 63776 appears 2 cycles after the pulse;
  - start is not replayed.
- `evt_food` during the start melody: food begins 2 cycles after start finishes (1 IDLE + 1 LOAD).
- All three pulses in the same cycle: only gameover plays, and `pend_food` and `pend_start` are cleared.
- Assert `reset_n` mid-note: all outputs are 0 immediately. After release there is no activity until a new pulse.
